// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared types and constants for the gate sweep controller
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;

    // Truth tables indexed by vector i = {a, b}
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_sweep_ctrl_if.sv
// rtl/gate_sweep_ctrl_if.sv - host and gate-side signals of the sweep controller
interface gate_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       z;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] observed;
    logic [2:0] err_cnt;
    logic [1:0] fail_idx;

    // master: the sweep controller itself
    modport master (
        input  start, abort, z,
        output a, b, busy, done, pass, observed, err_cnt, fail_idx
    );

    // slave: host plus gate under test
    modport slave (
        output start, abort, z,
        input  a, b, busy, done, pass, observed, err_cnt, fail_idx
    );
endinterface

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter flagging when the settle time is over
module settle_timer #(
    parameter int SETTLE_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                expired
);
    logic [SETTLE_W-1:0] count;

    // Load has priority; otherwise count down and rest at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through all vectors and checks its truth table
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int         SETTLE   = 4,
    parameter logic [3:0] EXPECT   = TT_AND,
    parameter int         SETTLE_W = 8
) (
    input logic               clk,
    input logic               rst_n,
    gate_sweep_ctrl_if.master sweep
);
    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_VEC - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic             a_q;
    logic             b_q;
    logic             pass_q;
    logic [3:0]       observed_q;
    logic [2:0]       err_q;
    logic [1:0]       fail_q;

    logic             expired;
    logic             clr;
    logic             accept;
    logic             do_sample;
    logic             timer_load;
    logic             last;
    logic             mismatch;
    logic [2:0]       err_sum;

    assign last     = (idx == LAST_IDX);
    assign mismatch = (sweep.z != EXPECT[idx]);
    assign err_sum  = err_q + {2'b00, mismatch};

    settle_timer #(.SETTLE_W(SETTLE_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (LOAD_VAL),
        .expired  (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: if (sweep.start) state_next = S_SETTLE;
            S_SETTLE:       if (expired)     state_next = S_SAMPLE;
            S_SAMPLE:       state_next = last ? S_DONE : S_SETTLE;
            default:        state_next = S_IDLE;
        endcase
        if (sweep.abort) state_next = S_IDLE;
    end

    // Control strobes derived from the current state and host inputs
    always_comb begin
        accept     = !sweep.abort && sweep.start && (state == S_IDLE || state == S_DONE);
        do_sample  = !sweep.abort && (state == S_SAMPLE);
        clr        = sweep.abort || accept;
        timer_load = accept || (do_sample && !last);
    end

    // Vector drive and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            pass_q     <= 1'b0;
            observed_q <= '0;
            err_q      <= '0;
            fail_q     <= '0;
        end else if (clr) begin
            idx        <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            pass_q     <= 1'b0;
            observed_q <= '0;
            err_q      <= '0;
            fail_q     <= '0;
        end else if (do_sample) begin
            observed_q[idx] <= sweep.z;
            err_q           <= err_sum;
            if (mismatch && err_q == '0) fail_q <= idx;
            if (last) begin
                pass_q <= (err_sum == '0);
            end else begin
                idx <= idx + 1'b1;
                {a_q, b_q} <= idx + 1'b1;
            end
        end
    end

    assign sweep.a        = a_q;
    assign sweep.b        = b_q;
    assign sweep.busy     = (state == S_SETTLE) || (state == S_SAMPLE);
    assign sweep.done     = (state == S_DONE);
    assign sweep.pass     = pass_q;
    assign sweep.observed = observed_q;
    assign sweep.err_cnt  = err_q;
    assign sweep.fail_idx = fail_q;
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - randomized self-checking bench for gate_sweep_ctrl
module tb_gate_sweep_ctrl;
    import gate_sweep_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] gate_tt = TT_AND;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;

    gate_sweep_ctrl_if if0 ();
    gate_sweep_ctrl_if if1 ();

    assign if0.start = start;
    assign if0.abort = abort;
    assign if0.z     = gate_tt[{if0.a, if0.b}];
    assign if1.start = start;
    assign if1.abort = abort;
    assign if1.z     = gate_tt[{if1.a, if1.b}];

    gate_sweep_ctrl #(.SETTLE(4), .EXPECT(TT_AND), .SETTLE_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .sweep(if0.master));
    gate_sweep_ctrl #(.SETTLE(1), .EXPECT(TT_XOR), .SETTLE_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .sweep(if1.master));

    always #5 clk = ~clk;

    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [3:0] m_obs;
    logic [2:0] m_err;
    logic [1:0] m_fail;

    always_comb begin
        m_a = if0.a; m_b = if0.b; m_busy = if0.busy; m_done = if0.done;
        m_pass = if0.pass; m_obs = if0.observed; m_err = if0.err_cnt; m_fail = if0.fail_idx;
        if (sel == 1) begin
            m_a = if1.a; m_b = if1.b; m_busy = if1.busy; m_done = if1.done;
            m_pass = if1.pass; m_obs = if1.observed; m_err = if1.err_cnt; m_fail = if1.fail_idx;
        end
    end

    task automatic do_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        abort = 1'b1;
        do_edge();
        abort = 1'b0;
    endtask

    // Sweep outcome derived from gate and expected truth tables
    function automatic void model(input logic [3:0] tt, input logic [3:0] ex,
                                  output logic [3:0] obs, output int err,
                                  output int fail, output logic pass);
        obs = tt;
        err = 0;
        fail = 0;
        for (int i = NUM_VEC - 1; i >= 0; i--) begin
            if (tt[i] != ex[i]) begin
                err++;
                fail = i;
            end
        end
        pass = (err == 0);
    endfunction

    // Start a sweep and follow it edge by edge; optional stray start at edge start_at
    task automatic check_sweep(input int s, input logic [3:0] ex, input int start_at, input string name);
        logic [3:0] e_obs;
        int         e_err, e_fail;
        logic       e_pass;
        int         vec;
        model(gate_tt, ex, e_obs, e_err, e_fail, e_pass);
        start = 1'b1;
        do_edge();
        start = 1'b0;
        for (int k = 0; k < 4 * (s + 1); k++) begin
            vec = k / (s + 1);
            total++;
            if ({m_a, m_b} !== 2'(vec) || m_busy !== 1'b1 || m_done !== 1'b0) begin
                bad++;
                $display("FAIL %s edge%0d ab/busy/done: got %b%b/%b/%b want %b/1/0",
                         name, k, m_a, m_b, m_busy, m_done, 2'(vec));
            end
            if (k + 1 == start_at) start = 1'b1;
            do_edge();
            start = 1'b0;
        end
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done/busy: got %b/%b want 1/0", name, m_done, m_busy);
        end
        total++;
        if (m_pass !== e_pass || m_obs !== e_obs || m_err !== 3'(e_err) || m_fail !== 2'(e_fail)) begin
            bad++;
            $display("FAIL %s results pass/obs/err/fail: got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                     name, m_pass, m_obs, m_err, m_fail, e_pass, e_obs, e_err, e_fail);
        end
    endtask

    task automatic check_cleared(input string name);
        total++;
        if ({m_a, m_b, m_busy, m_done, m_pass, m_obs, m_err, m_fail} !== 14'd0) begin
            bad++;
            $display("FAIL %s all-zero: got a%b b%b busy%b done%b pass%b obs%b err%0d fail%0d want 0",
                     name, m_a, m_b, m_busy, m_done, m_pass, m_obs, m_err, m_fail);
        end
    endtask

    task automatic test_reset();
        sel = 0;
        #2;
        check_cleared("reset_initial");
        @(negedge clk);
        rst_n = 1'b1;
        gate_tt = TT_AND;
        start = 1'b1;
        do_edge();
        start = 1'b0;
        repeat (7) do_edge();
        #2;
        rst_n = 1'b0;
        #1;
        check_cleared("reset_async_mid");
        @(negedge clk);
        rst_n = 1'b1;
        check_sweep(4, TT_AND, -1, "after_reset");
    endtask

    task automatic test_and();
        sel = 0; go_idle();
        gate_tt = TT_AND;
        check_sweep(4, TT_AND, -1, "and_gate");
    endtask

    task automatic test_faults();
        sel = 0; go_idle();
        gate_tt = 4'b0000;
        check_sweep(4, TT_AND, -1, "stuck0");
        go_idle();
        gate_tt = TT_OR;
        check_sweep(4, TT_AND, -1, "or_vs_and");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            sel = n % 2;
            go_idle();
            gate_tt = 4'($urandom);
            if (sel == 0) check_sweep(4, TT_AND, -1, "rand_s4");
            else          check_sweep(1, TT_XOR, -1, "rand_s1");
        end
    endtask

    task automatic test_overlap();
        sel = 0; go_idle();
        gate_tt = TT_NAND;
        check_sweep(4, TT_AND, 3, "start_ignored");
    endtask

    task automatic test_abort();
        sel = 0; go_idle();
        gate_tt = 4'($urandom) | 4'b0001;
        start = 1'b1;
        do_edge();
        start = 1'b0;
        repeat (6) do_edge();
        abort = 1'b1;
        do_edge();
        abort = 1'b0;
        check_cleared("abort_mid");
        gate_tt = TT_OR;
        check_sweep(4, TT_AND, -1, "pre_abort_done");
        abort = 1'b1;
        do_edge();
        abort = 1'b0;
        check_cleared("abort_done");
        start = 1'b1;
        abort = 1'b1;
        do_edge();
        start = 1'b0;
        abort = 1'b0;
        check_cleared("start_abort_same");
        repeat (3) do_edge();
        check_cleared("start_abort_stays_idle");
    endtask

    task automatic test_back_to_back();
        sel = 1; go_idle();
        gate_tt = TT_XOR;
        check_sweep(1, TT_XOR, -1, "xor_first");
        gate_tt = 4'($urandom);
        check_sweep(1, TT_XOR, -1, "xor_second");
    endtask

    initial begin
        test_reset();
        test_and();
        test_faults();
        test_random();
        test_overlap();
        test_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Self-checking sequencer for a two-input, one-output combinational gate. On `start` it drives the gate's `a`/`b` inputs through all four combinations, waits a programmable settle time per vector and samples `z`. It compares each sample against an expected truth table and reports pass/fail, the captured truth table, the mismatch count and the first failing vector. It sits between the gate under test and a host/status block, replacing hand-written stimulus with an on-chip sweep.

## Interface
Parameters:
- `SETTLE`, default 4: clock cycles `a`/`b` are held before `z` is sampled; legal range 1..255.
- `EXPECT`, default 4'b1000: expected `z` per vector index i; bit i is the expected value, and the default is an AND gate.
- `SETTLE_W`, default 8: settle counter width; must hold `SETTLE-1`.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a sweep; sampled each edge.
- `abort` in 1: cancel a sweep; sampled each edge.
- `z` in 1: gate output; same clock domain, not synchronized.
- `a` out 1: gate input, registered.
- `b` out 1: gate input, registered.
- `busy` out 1: sweep in progress.
- `done` out 1: sweep complete; level signal.
- `pass` out 1: all four vectors matched; valid while `done`.
- `observed` out 4: captured `z`; bit i is the value for vector i.
- `err_cnt` out 3: number of mismatches, 0..4.
- `fail_idx` out 2: lowest mismatching index; 0 when `pass`.

## Operation
- Vector index i maps to `a = i[1]`, `b = i[0]`. Order is 0,1,2,3, i.e. (0,0), (0,1), (1,0), (1,1).
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, and `start`=1 with `abort`=0:
  - clear `observed`, `err_cnt`, `fail_idx`, `pass` and `done`;
  - set idx to 0 and drive `a`=`b`=0;
  - load settle count with `SETTLE-1`; next state SETTLE.
- SETTLE: decrement the count. When the count is 0, move to SAMPLE.
- SAMPLE:
  - write `observed[idx]` <= `z`;
  - on mismatch against `EXPECT[idx]`, increment `err_cnt`; if it was 0, set `fail_idx` to idx;
  - if idx is 3, go to DONE and set `pass` = (final `err_cnt` == 0);
  - otherwise increment idx, drive the new `a`/`b`, reload the count and go to SETTLE.
- DONE: `done`=1 and results are held until the next `start`, `abort` or reset.
- `start` while `busy`: ignored.
- `abort`=1 in any state, on the next edge:
  - go to IDLE and drive `a`=`b`=0;
  - set `busy`, `done`, `pass`, `observed`, `err_cnt` and `fail_idx` to 0.
- `abort` and `start` asserted together: `abort` wins and no sweep starts.
- `busy`=1 exactly in SETTLE and SAMPLE.

## Timing
- Reset (async assert, any state): state IDLE and every output 0.
- Deassertion of `rst_n` is synchronized externally. The first accepted `start` is at the first edge after deassertion.
- Per vector: `SETTLE`+1 edges. `a`/`b` change on the edge entering SETTLE, and `z` is sampled on the edge leaving SAMPLE.
- Latency: if `start` is accepted at edge 0, `done` rises after edge 4·(`SETTLE`+1), i.e. 20 edges with the default.
- Results update on the sampling edge. `pass` and `done` become valid on the same edge.
- From DONE, a `start` drops `done` on the very next edge, so back-to-back sweeps have no dead cycle.
- `z` must be stable for `SETTLE` cycles after an `a`/`b` change. Meeting that is the integrator's responsibility.

## Structure
- `gate_sweep_pkg` holds:
  - the state enum typedef (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3);
  - `NUM_VEC`=4 and `IDX_W`=2;
  - the default `EXPECT` constants `TT_AND`=4'b1000, `TT_OR`=4'b1110, `TT_XOR`=4'b0110 and `TT_NAND`=4'b0111.
- Sub-module `settle_timer`:
  - inputs: `load` and `load_val` [`SETTLE_W`];
  - output: `expired`, asserted when the count is 0;
  - it counts down when not loaded.
- All remaining logic lives in `gate_sweep_ctrl`. No other sub-modules.

## Test plan
- Reset asserted mid-sweep at cycle 7: all outputs go to 0 immediately (async), state IDLE. After release, a `start` yields a full sweep.
- AND gate model, default parameters, pulse `start`:
  - `a`/`b` step through 00, 01, 10, 11 every 5 cycles;
  - `done` rises 20 edges later with `pass`=1, `observed`=4'b1000, `err_cnt`=0, `fail_idx`=0.
- `z` stuck at 0, `EXPECT`=`TT_AND`: `observed`=4'b0000, `err_cnt`=1, `fail_idx`=3, `pass`=0.
- OR gate model, `EXPECT`=`TT_AND`: `observed`=4'b1110, `err_cnt`=2, `fail_idx`=1, `pass`=0.
- Abort and overlap:
  - `abort` at edge 7 after `start`: IDLE on the next edge with `a`=`b`=0 and `busy`=0;
  - `start` pulsed at edge 3 during a sweep is ignored, so `done` still lands at edge 20;
  - `start` and `abort` together from IDLE: no sweep starts.
- `SETTLE`=1, XOR model with `EXPECT`=`TT_XOR`:
  - `done` after 8 edges with `pass`=1;
  - a `start` in DONE drops `done` next edge and a second sweep completes 8 edges later.
